sig_measure: RTL and testbench

SIG_MEASURE -- requirements
Module: sig_measure

---
 rtl/sig_measure_pkg.sv | 21 ++
 rtl/zc_detect.sv | 82 ++++++++
 rtl/sig_measure.sv | 154 +++++++++++++++
 tb/tb_sig_measure.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sig_measure_pkg.sv
// sig_measure_pkg -- encodings shared by the signal-measurement block.
//   state_e : window FSM states (IDLE, ACC, PUB)
//   hyst_e  : zero-crossing hysteresis states (UNK, LOW, HIGH)
//   ZC_SAT  : ceiling of the 16-bit zero-crossing counter
package sig_measure_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_PUB  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HY_UNK  = 2'd0,
    HY_LOW  = 2'd1,
    HY_HIGH = 2'd2
  } hyst_e;

  localparam logic [15:0] ZC_SAT = 16'hFFFF;

endpackage

// File: rtl/zc_detect.sv
// zc_detect -- hysteresis zero-crossing detector with per-window counter.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   strobe_i       : one sample is consumed this clk
//   new_win_i      : this sample is the first of a new window (clears count)
//   din_i [DW-1:0] : two's-complement sample
//   cnt_d_o [15:0] : window count including the current sample
//   sat_d_o        : sticky saturation flag including the current sample
// The next-state values are exported so the parent can capture the count in
// the same clk that consumes the final sample of a window.
module zc_detect
  import sig_measure_pkg::*;
#(
  parameter int DW   = 12,
  parameter int HYST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strobe_i,
  input  logic          new_win_i,
  input  logic [DW-1:0] din_i,
  output logic [15:0]   cnt_d_o,
  output logic          sat_d_o
);

  localparam int HI_TH = HYST;
  localparam int LO_TH = -HYST;

  hyst_e       hyst_q, hyst_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sat_q, sat_d;
  logic signed [DW-1:0] din_s;
  int          din_int;

  assign din_s   = din_i;
  assign din_int = int'(din_s);

  // NOTE: every variable gets a default before any branch so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    hyst_d = hyst_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    if (strobe_i) begin
      if (new_win_i) begin
        cnt_d = '0;
        sat_d = 1'b0;
      end
      // Samples inside the dead band leave the state untouched.
      if (din_int <= LO_TH) begin
        hyst_d = HY_LOW;
      end else if (din_int >= HI_TH) begin
        hyst_d = HY_HIGH;
      end
      // Only a genuine LOW->HIGH move counts; leaving UNK never does.
      if (hyst_q == HY_LOW && hyst_d == HY_HIGH && cnt_d != ZC_SAT) begin
        cnt_d = cnt_d + 16'd1;
        if (cnt_d == ZC_SAT) begin
          sat_d = 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hyst_q <= HY_UNK;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      hyst_q <= hyst_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign cnt_d_o = cnt_d;
  assign sat_d_o = sat_d;

endmodule

// File: rtl/sig_measure.sv
// sig_measure -- windowed peak / peak-to-peak / zero-crossing measurement.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   f_s             : sample-rate clock, used as a clk-synchronous level
//   din [DW-1:0]    : two's-complement sample
//   valid           : one-clk pulse, results below are new
//   peak_max/min    : signed extremes of the last window
//   p2p [DW:0]      : unsigned peak_max - peak_min
//   zc_count [15:0] : positive-going zero crossings in the last window
//   zc_sat          : zc_count saturated during the last window
module sig_measure
  import sig_measure_pkg::*;
#(
  parameter int DW   = 12,
  parameter int WIN  = 2000,
  parameter int HYST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_s,
  input  logic [DW-1:0] din,
  output logic          valid,
  output logic [DW-1:0] peak_max,
  output logic [DW-1:0] peak_min,
  output logic [DW:0]   p2p,
  output logic [15:0]   zc_count,
  output logic          zc_sat
);

  localparam logic [15:0] WIN_C = 16'(WIN);

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic signed [DW-1:0] max_q, max_d, min_q, min_d;
  logic signed [DW-1:0] din_s;
  logic                 f_s_q, strobe, new_win, publish;
  logic [DW:0]          p2p_d;
  logic [15:0]          zc_cnt_d;
  logic                 zc_sat_d;

  logic                 valid_q;
  logic [DW-1:0]        peak_max_q, peak_min_q;
  logic [DW:0]          p2p_q;
  logic [15:0]          zc_count_q;
  logic                 zc_sat_q;

  assign din_s   = din;
  // Rising edge of f_s; a level held high produces a single strobe.
  assign strobe  = f_s & ~f_s_q;
  // A window starts on the first strobe after reset, or right after PUB.
  assign new_win = strobe &&
                   (state_q == ST_IDLE || (state_q == ST_ACC && cnt_q == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    min_d   = min_q;
    publish = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          max_d   = din_s;
          min_d   = din_s;
          cnt_d   = 16'd1;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (strobe) begin
          if (cnt_q == '0) begin
            max_d = din_s;
            min_d = din_s;
          end else begin
            if (din_s > max_q) max_d = din_s;
            if (din_s < min_q) min_d = din_s;
          end
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == WIN_C) begin
            state_d = ST_PUB;
            publish = 1'b1;
          end
        end
      end
      ST_PUB: begin
        state_d = ST_ACC;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sign-extend before subtracting so the full range fits without overflow.
  assign p2p_d = {max_d[DW-1], max_d} - {min_d[DW-1], min_d};

  zc_detect #(
    .DW   (DW),
    .HYST (HYST)
  ) u_zc (
    .clk       (clk),
    .rst       (rst),
    .strobe_i  (strobe),
    .new_win_i (new_win),
    .din_i     (din),
    .cnt_d_o   (zc_cnt_d),
    .sat_d_o   (zc_sat_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      max_q   <= '0;
      min_q   <= '0;
      f_s_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      min_q   <= min_d;
      f_s_q   <= f_s;
    end
  end

  // Results are captured on the edge that consumes the last sample, so they
  // appear together with valid during the PUB clk and hold until the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      peak_max_q <= '0;
      peak_min_q <= '0;
      p2p_q      <= '0;
      zc_count_q <= '0;
      zc_sat_q   <= 1'b0;
    end else begin
      valid_q <= publish;
      if (publish) begin
        peak_max_q <= max_d;
        peak_min_q <= min_d;
        p2p_q      <= p2p_d;
        zc_count_q <= zc_cnt_d;
        zc_sat_q   <= zc_sat_d;
      end
    end
  end

  assign valid    = valid_q;
  assign peak_max = peak_max_q;
  assign peak_min = peak_min_q;
  assign p2p      = p2p_q;
  assign zc_count = zc_count_q;
  assign zc_sat   = zc_sat_q;

endmodule

// File: tb/tb_sig_measure.sv
// tb_sig_measure -- directed bench for sig_measure (WIN=8, HYST=16, DW=12).
// Expected window results come from a small behavioural model, are queued
// when a window is driven and compared when valid pulses.
module tb_sig_measure;

  localparam int DW     = 12;
  localparam int WIN    = 8;
  localparam int HYST   = 16;
  localparam int FS_PER = 100;
  localparam int FS_HI  = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_s = 1'b0;
  logic [DW-1:0] din = '0;
  logic          valid;
  logic [DW-1:0] peak_max, peak_min;
  logic [DW:0]   p2p;
  logic [15:0]   zc_count;
  logic          zc_sat;

  sig_measure #(
    .DW   (DW),
    .WIN  (WIN),
    .HYST (HYST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .f_s      (f_s),
    .din      (din),
    .valid    (valid),
    .peak_max (peak_max),
    .peak_min (peak_min),
    .p2p      (p2p),
    .zc_count (zc_count),
    .zc_sat   (zc_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;
    logic [DW:0]   p2p;
    logic [15:0]   zc;
    logic          sat;
  } exp_t;

  exp_t sb[$];
  int   errors     = 0;
  int   checks     = 0;
  int   valid_seen = 0;
  int   hy         = 0;  // model hysteresis: 0 UNK, 1 LOW, 2 HIGH
  logic signed [DW-1:0] win_s [WIN];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest window.
  always @(negedge clk) begin : mon
    exp_t e;
    if (valid === 1'b1) begin
      valid_seen++;
      if (sb.size() == 0) begin
        check("valid_unexpected", 32'(valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("peak_max", 32'(peak_max), 32'(e.mx));
        check("peak_min", 32'(peak_min), 32'(e.mn));
        check("p2p",      32'(p2p),      32'(e.p2p));
        check("zc_count", 32'(zc_count), 32'(e.zc));
        check("zc_sat",   32'(zc_sat),   32'(e.sat));
      end
    end
  end

  function automatic exp_t model_window();
    exp_t e;
    int mx = -100000;
    int mn = 100000;
    int zc = 0;
    int v, old;
    for (int i = 0; i < WIN; i++) begin
      v = int'(win_s[i]);
      if (v > mx) mx = v;
      if (v < mn) mn = v;
      old = hy;
      if (v <= -HYST) hy = 1;
      else if (v >= HYST) hy = 2;
      if (old == 1 && hy == 2) zc++;
    end
    e.mx  = DW'(mx);
    e.mn  = DW'(mn);
    e.p2p = (DW+1)'(mx - mn);
    e.zc  = 16'(zc);
    e.sat = 1'b0;
    return e;
  endfunction

  // One f_s period starting at a negedge; valid is checked one clk after
  // the rising edge of f_s.
  task automatic send(input logic [DW-1:0] v, input int hi, input logic last);
    din = v;
    f_s = 1'b1;
    @(negedge clk);
    check("valid_timing", 32'(valid), 32'(last));
    repeat (hi - 1) @(negedge clk);
    f_s = 1'b0;
    repeat (FS_PER - FS_HI) @(negedge clk);
  endtask

  task automatic run_window(input int hold_idx);
    exp_t e;
    e = model_window();
    sb.push_back(e);
    for (int i = 0; i < WIN; i++) begin
      send(win_s[i], (i == hold_idx) ? 300 : FS_HI, i == WIN - 1);
    end
    check("hold_peak_max", 32'(peak_max), 32'(e.mx));
    check("hold_zc_count", 32'(zc_count), 32'(e.zc));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},    32'(valid),    32'd0);
    check({tag, "_peak_max"}, 32'(peak_max), 32'd0);
    check({tag, "_peak_min"}, 32'(peak_min), 32'd0);
    check({tag, "_p2p"},      32'(p2p),      32'd0);
    check({tag, "_zc_count"}, 32'(zc_count), 32'd0);
    check({tag, "_zc_sat"},   32'(zc_sat),   32'd0);
  endtask

  initial begin
    // Reset held while f_s toggles: nothing may come out.
    rst = 1'b1;
    @(negedge clk);
    send(DW'(300),  FS_HI, 1'b0);
    send(DW'(-300), FS_HI, 1'b0);
    send(DW'(700),  FS_HI, 1'b0);
    check_zero_outputs("rst_hold");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Constant 100.
    for (int i = 0; i < WIN; i++) win_s[i] = DW'(100);
    run_window(-1);
    check("valid_count_w1", 32'(valid_seen), 32'd1);

    // Alternating +/-500, two windows (second sees the carried LOW state).
    for (int i = 0; i < WIN; i++) win_s[i] = (i % 2 == 0) ? DW'(500) : DW'(-500);
    run_window(-1);
    run_window(-1);

    // Full-scale extremes.
    win_s[0] = DW'(2047);
    win_s[1] = DW'(-2048);
    for (int i = 2; i < WIN; i++) win_s[i] = '0;
    run_window(-1);

    // Inside hysteresis, with one f_s held high for 300 clk.
    for (int i = 0; i < WIN; i++) win_s[i] = (i % 2 == 0) ? DW'(10) : DW'(-10);
    run_window(3);

    // Reset after the 5th strobe of a window.
    for (int i = 0; i < 5; i++) send((i % 2 == 0) ? DW'(300) : DW'(-300), FS_HI, 1'b0);
    rst = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    hy  = 0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < WIN; i++) win_s[i] = DW'(-7);
    run_window(-1);

    repeat (5) @(negedge clk);
    check("valid_count_total", 32'(valid_seen), 32'd6);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
